vfpm_result_drain: RTL and testbench
====================================

Name: vfpm_result_drain

Overview:
- Receives the result stream from the vector FP multiplier pipeline: one 32-bit IEEE-754 product plus an exception flag per cycle.
- Buffers up to one full vector of 32 results.
- Once the vector is complete, drains the results to a downstream consumer over a valid/ready handshake, in index order, with a last marker and a flag summary.
- Sits after the rounding/result register stage; it is the reading end of the result write-back path.

Parameters:
- DEPTH, 32, results per vector (power of two).
- AW, 5, index width (log2 DEPTH).
- WIDTH, 32, result word width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- res_valid  in  1  result word present this cycle.
- res_data  in  WIDTH  result word.
- res_flag  in  1  exception flag for this word.
- vec_done  in  1  producer finished the vector; may be short of DEPTH.
- out_valid  out  1  out_data/out_flag/out_index valid.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  drained result.
- out_flag  out  1  drained exception flag.
- out_index  out  AW  element index 0..count-1.
- out_last  out  1  final element of vector.
- drain_done  out  1  one-cycle pulse after last transfer.
- flag_count  out  AW+1  number of flagged results in current vector.
- overflow  out  1  sticky; a result was dropped.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state IDLE, wr_ptr=0, rd_ptr=0, count=0. Buffer contents are don't-care.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - res_valid writes buf[0], sets count=1, flag_count=res_flag, goes to FILL.
  - vec_done alone is ignored.
- FILL:
  - Each res_valid writes buf[wr_ptr] and increments wr_ptr/count; flag_count += res_flag.
  - Go to DRAIN when count reaches DEPTH after the write, or when vec_done=1.
  - res_valid together with vec_done in the same cycle: the word is captured first, then DRAIN.
- DRAIN:
  - Output registers load buf[rd_ptr]; out_valid rises one cycle after DRAIN is entered.
  - Transfer occurs on out_valid && out_ready. Next element is presented the following cycle.
  - Sustained ready gives 1 word/cycle: with a 1-cycle buffer read, out_valid holds high through back-to-back transfers via prefetch of rd_ptr+1.
  - out_data/flag/index stay stable while out_valid && !out_ready.
  - out_last=1 exactly when out_index==count-1.
  - The transfer with out_last moves to DONE; out_valid drops next cycle.
- DONE:
  - drain_done=1 for exactly one cycle.
  - Clears wr_ptr, rd_ptr, count, then returns to IDLE.
  - flag_count holds its value until the first write of the next vector.
- Dropped results:
  - res_valid in DRAIN or DONE drops the word and sets overflow.
  - res_valid in FILL at count==DEPTH cannot occur, because the state has already left FILL.
- overflow clears only on reset.
- Pointers are AW bits; count is AW+1 bits so DEPTH is representable; no wrap within a vector.
- Reset mid-DRAIN: out_valid drops immediately (asynchronous); the partial vector is discarded.
- No combinational path from out_ready to out_valid.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/FILL/DRAIN/DONE);
  - VFPM_DEPTH=32 and VFPM_AW=5, also used by the pipeline top;
  - WIDTH=32.
- One sub-module: vfpm_result_ram.
  - DEPTH x (WIDTH+1) storage (data plus flag).
  - Synchronous write, registered read.
- The drain FSM, pointers and counters stay in the top.

Test Plan:
- Full vector: 32 consecutive res_valid with data 32'h3F80_0000+i and flag=(i==5 || i==17); out_ready=1 -> 32 transfers in order; flag_count=2; out_last only at index 31; drain_done pulses once, one cycle after that transfer.
- Short vector: 3 words 32'h4000_0000, 32'h4040_0000, 32'h7F80_0000 (flag=1 on the third), vec_done with the third -> drain indices 0..2, out_last at index 2, flag_count=1.
- Backpressure: full vector with out_ready toggling 1,0,0,1 -> each element held stable while stalled; no element dropped or duplicated; 32 transfers total.
- Overflow: res_valid=1 during DRAIN with data 32'hDEAD_BEEF -> word never appears on out_data; overflow=1 and stays 1 through the next vector.
- Reset mid-drain: assert reset after 10 transfers -> out_valid=0, busy=0, overflow=0 at once; a following 32-word vector drains normally from index 0.
- Idle robustness: vec_done pulsed in IDLE with no results -> state remains IDLE, out_valid never asserts, drain_done stays 0.

Source files
------------

// File: rtl/vfpm_result_drain_pkg.sv
// Shared definitions for the vector FP multiplier result path:
// vector geometry, result word width and the drain FSM state encoding.
package vfpm_result_drain_pkg;

  localparam int unsigned VFPM_DEPTH = 32;
  localparam int unsigned VFPM_AW    = 5;
  localparam int unsigned VFPM_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/vfpm_result_ram.sv
// Result buffer: one vector of {flag, data} words, synchronous write,
// registered read (read data appears the cycle after the address).
module vfpm_result_ram
  import vfpm_result_drain_pkg::*;
#(
  parameter int unsigned DEPTH = VFPM_DEPTH,
  parameter int unsigned AW    = VFPM_AW,
  parameter int unsigned DW    = VFPM_WIDTH + 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/vfpm_result_drain.sv
// Collects one vector of multiplier results, then drains them in index
// order over valid/ready with a last marker, flag count and overflow flag.
module vfpm_result_drain
  import vfpm_result_drain_pkg::*;
#(
  parameter int unsigned DEPTH = VFPM_DEPTH,
  parameter int unsigned AW    = VFPM_AW,
  parameter int unsigned WIDTH = VFPM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  input  logic             res_flag,
  input  logic             vec_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_flag,
  output logic [AW-1:0]    out_index,
  output logic             out_last,
  output logic             drain_done,
  output logic [AW:0]      flag_count,
  output logic             overflow,
  output logic             busy
);

  localparam logic [AW:0]   C_FULL    = DEPTH[AW:0];
  localparam logic [AW:0]   C_ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] C_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  drain_state_t r_state, w_next;

  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_raddr;
  logic [AW:0]   r_count, r_flag_count;
  logic          r_overflow, r_out_valid;
  logic          w_we, w_drop, w_xfer, w_last;
  logic [WIDTH:0] w_rdata;

  assign w_xfer = r_out_valid && out_ready;
  assign w_last = ({1'b0, r_rd_ptr} == (r_count - C_ONE));
  // Prefetch the next element on a transfer so sustained ready gives one word per cycle.
  assign w_raddr = (w_xfer && !w_last) ? (r_rd_ptr + C_PTR_ONE) : r_rd_ptr;

  vfpm_result_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (WIDTH + 1)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata ({res_flag, res_data}),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (res_valid) w_next = ST_FILL;
      ST_FILL:  if (vec_done || (res_valid && (r_count == (C_FULL - C_ONE)))) w_next = ST_DRAIN;
      ST_DRAIN: if (w_xfer && w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_we       = 1'b0;
    w_drop     = 1'b0;
    busy       = 1'b1;
    drain_done = 1'b0;
    case (r_state)
      ST_IDLE:  begin busy = 1'b0; w_we = res_valid; end
      ST_FILL:  w_we = res_valid;
      ST_DRAIN: w_drop = res_valid;
      ST_DONE:  begin drain_done = 1'b1; w_drop = res_valid; end
      default:  busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_flag_count <= '0;
      r_overflow   <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (res_valid) begin
            r_wr_ptr     <= C_PTR_ONE;
            r_count      <= C_ONE;
            r_flag_count <= {{AW{1'b0}}, res_flag};
          end
        end
        ST_FILL: begin
          if (res_valid) begin
            r_wr_ptr     <= r_wr_ptr + C_PTR_ONE;
            r_count      <= r_count + C_ONE;
            r_flag_count <= r_flag_count + {{AW{1'b0}}, res_flag};
          end
        end
        ST_DRAIN: begin
          r_out_valid <= !(w_xfer && w_last);
          if (w_xfer && !w_last) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
          end
        end
        ST_DONE: begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end
        default: ;
      endcase
    end
  end

  // The buffer read register has no reset, so drained fields are masked while not valid.
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_valid ? w_rdata[WIDTH-1:0] : '0;
  assign out_flag   = r_out_valid & w_rdata[WIDTH];
  assign out_index  = r_rd_ptr;
  assign out_last   = r_out_valid & w_last;
  assign flag_count = r_flag_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_vfpm_result_drain.sv
// Directed bench for vfpm_result_drain: full, short, backpressured and
// overflowing vectors, reset during drain, and vec_done pulsed while idle.
module tb_vfpm_result_drain;
  import vfpm_result_drain_pkg::*;

  localparam int unsigned W  = VFPM_WIDTH;
  localparam int unsigned AW = VFPM_AW;
  localparam int unsigned N  = VFPM_DEPTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          res_valid = 1'b0;
  logic [W-1:0]  res_data = '0;
  logic          res_flag = 1'b0;
  logic          vec_done = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid, out_flag, out_last, drain_done, overflow, busy;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_index;
  logic [AW:0]   flag_count;

  logic [W-1:0]  exp_d [N];
  logic          exp_f [N];
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  vfpm_result_drain #(
    .DEPTH (N),
    .AW    (AW),
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_flag   (res_flag),
    .vec_done   (vec_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_flag   (out_flag),
    .out_index  (out_index),
    .out_last   (out_last),
    .drain_done (drain_done),
    .flag_count (flag_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input bit with_done);
    for (int i = 0; i < n; i++) begin
      res_valid = 1'b1;
      res_data  = exp_d[i];
      res_flag  = exp_f[i];
      vec_done  = with_done && (i == n - 1);
      step();
    end
    res_valid = 1'b0;
    res_flag  = 1'b0;
    res_data  = '0;
    vec_done  = 1'b0;
  endtask

  // Entered in the first DRAIN cycle; returns in the cycle after drain_done.
  task automatic drain(input int n, input bit bp, input bit inject);
    int            k = 0;
    int            cyc = 0;
    bit            stalled = 1'b0;
    logic [W-1:0]  h_d = '0;
    logic [AW-1:0] h_i = '0;
    for (int c = 0; c < 400 && k < n; c++) begin
      out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      res_valid = inject && (c < 3);
      res_data  = 32'hDEAD_BEEF;
      res_flag  = inject;
      if (c == 0) check_eq("valid_lat0", out_valid, 1'b0);
      if (c == 1) check_eq("valid_lat1", out_valid, 1'b1);
      if (out_valid) begin
        if (stalled) begin
          check_eq("hold_data", out_data, h_d);
          check_eq("hold_index", out_index, h_i);
        end
        if (out_ready) begin
          check_eq("data", out_data, exp_d[k]);
          check_eq("flag", out_flag, exp_f[k]);
          check_eq("index", out_index, k);
          check_eq("last", out_last, (k == n - 1));
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          h_d = out_data;
          h_i = out_index;
        end
      end
      cyc++;
      step();
    end
    res_valid = 1'b0;
    res_flag  = 1'b0;
    res_data  = '0;
    out_ready = 1'b0;
    check_eq("xfer_count", k, n);
    if (!bp) check_eq("drain_cycles", cyc, n + 1);
    check_eq("done_pulse", drain_done, 1'b1);
    check_eq("valid_after_last", out_valid, 1'b0);
    step();
    check_eq("done_single", drain_done, 1'b0);
    check_eq("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int k;
    #1;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", drain_done, 1'b0);
    check_eq("rst_ovf", overflow, 1'b0);
    check_eq("rst_fcnt", flag_count, 0);
    check_eq("rst_last", out_last, 1'b0);
    check_eq("rst_data", out_data, 0);
    step();
    step();
    reset = 1'b0;

    // Full vector
    for (int i = 0; i < int'(N); i++) begin
      exp_d[i] = 32'h3F80_0000 + i;
      exp_f[i] = (i == 5) || (i == 17);
    end
    fill(32, 1'b0);
    check_eq("full_fcnt", flag_count, 2);
    check_eq("full_busy", busy, 1'b1);
    drain(32, 1'b0, 1'b0);
    check_eq("full_ovf", overflow, 1'b0);
    check_eq("fcnt_hold", flag_count, 2);

    // Short vector ending with vec_done on the third word
    exp_d[0] = 32'h4000_0000; exp_f[0] = 1'b0;
    exp_d[1] = 32'h4040_0000; exp_f[1] = 1'b0;
    exp_d[2] = 32'h7F80_0000; exp_f[2] = 1'b1;
    fill(3, 1'b1);
    check_eq("short_fcnt", flag_count, 1);
    drain(3, 1'b0, 1'b0);

    // Results arriving during DRAIN are dropped
    for (int i = 0; i < 4; i++) begin
      exp_d[i] = 32'h4080_0000 + (i << 4);
      exp_f[i] = 1'b0;
    end
    fill(4, 1'b1);
    drain(4, 1'b0, 1'b1);
    check_eq("ovf_set", overflow, 1'b1);
    check_eq("ovf_fcnt", flag_count, 0);

    // Backpressure with ready pattern 1,0,0,1
    for (int i = 0; i < int'(N); i++) begin
      exp_d[i] = 32'h4280_0000 + (i << 8);
      exp_f[i] = (i == 0) || (i == 31);
    end
    fill(32, 1'b0);
    check_eq("bp_fcnt", flag_count, 2);
    drain(32, 1'b1, 1'b0);
    check_eq("ovf_sticky", overflow, 1'b1);

    // Reset after 10 transfers
    fill(32, 1'b0);
    out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 100 && k < 10; c++) begin
      if (out_valid) k++;
      step();
    end
    check_eq("pre_rst_xfers", k, 10);
    check_eq("pre_rst_index", out_index, 10);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_ovf", overflow, 1'b0);
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      exp_d[i] = 32'hC000_0000 | i;
      exp_f[i] = i[0];
    end
    fill(32, 1'b0);
    check_eq("post_rst_fcnt", flag_count, 16);
    drain(32, 1'b0, 1'b0);

    // vec_done alone in IDLE
    vec_done = 1'b1;
    step();
    vec_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check_eq("idle_busy_vd", busy, 1'b0);
      check_eq("idle_valid_vd", out_valid, 1'b0);
      check_eq("idle_done_vd", drain_done, 1'b0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
